mp_add_seq: RTL



---
 rtl/mp_add_pkg.sv | 19 +
 rtl/mp_add_seq_if.sv | 31 +++
 rtl/rca_slice.sv | 27 ++
 rtl/mp_add_seq.sv | 93 +++++++++
 4 files changed

// File: rtl/mp_add_pkg.sv
// Shared types and helpers for the multi-precision add sequencer.
// Holds the controller state encoding, default geometry and word-slice indexing.
package mp_add_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefWords = 4;

  // LSB position of word k inside a packed multi-word operand.
  function automatic int unsigned word_lsb(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/mp_add_seq_if.sv
// Request/response bus of the multi-precision add sequencer.
// The master modport is the requester/consumer side; the slave modport is the sequencer.
interface mp_add_seq_if
  import mp_add_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned WORDS = DefWords
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH*WORDS-1:0]   a;
  logic [WIDTH*WORDS-1:0]   b;
  logic                     cin;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH*WORDS-1:0]   sum;
  logic                     cout;
  logic                     busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/rca_slice.sv
// Combinational WIDTH-bit ripple-carry adder built from a chain of full adders.
module rca_slice #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Each stage owns its carry nets so the ripple is a chain of distinct signals.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic ci;
    logic co;
    if (i == 0) begin : g_first
      assign ci = cin;
    end else begin : g_next
      assign ci = g_fa[i-1].co;
    end
    assign sum[i] = a[i] ^ b[i] ^ ci;
    assign co     = (a[i] & b[i]) | (ci & (a[i] ^ b[i]));
  end

  assign cout = g_fa[WIDTH-1].co;

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision adder: one WIDTH-bit slice reused over WORDS cycles with a registered carry.
// Captures operands in IDLE, adds one word per cycle in RUN, holds the result in DONE.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned WORDS = DefWords
) (
  input logic        clk,
  input logic        rst_n,
  mp_add_seq_if.slave bus
);

  localparam int unsigned N    = WIDTH * WORDS;
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e            state_q;
  logic [N-1:0]      a_q;
  logic [N-1:0]      b_q;
  logic [N-1:0]      sum_q;
  logic [IdxW-1:0]   idx_q;
  logic              carry_q;
  logic              cout_q;

  logic [WIDTH-1:0]  slice_a;
  logic [WIDTH-1:0]  slice_b;
  logic [WIDTH-1:0]  slice_s;
  logic              slice_c;

  always_comb begin
    slice_a = a_q[word_lsb(32'(idx_q), WIDTH) +: WIDTH];
    slice_b = b_q[word_lsb(32'(idx_q), WIDTH) +: WIDTH];
  end

  rca_slice #(
    .WIDTH(WIDTH)
  ) u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry_q),
    .sum (slice_s),
    .cout(slice_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // sum_q is deliberately left untouched so the last result stays visible.
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            idx_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          sum_q[word_lsb(32'(idx_q), WIDTH) +: WIDTH] <= slice_s;
          carry_q <= slice_c;
          if (idx_q == IdxW'(WORDS - 1)) begin
            cout_q  <= slice_c;
            idx_q   <= '0;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule
